// File: rtl/exec_dispatch_scheduler.sv
// ============================================================================
// exec_dispatch_scheduler : issues decoded instructions to ALU/MEMIO/PFCU and
// retires them. Optional WAIT watchdog: DISPATCH_WATCHDOG_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module exec_dispatch_scheduler #(
  parameter int INST_W         = 48,
  parameter int FLUSH_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_inst_pres,
  input  logic [INST_W-1:0] i_curr_inst,
  input  logic              i_alu_done,
  input  logic              i_mem_done,
  input  logic              i_pfcu_done,
  input  logic              i_mdfy_pc,
  output logic              o_rq_nxt_inst,
  output logic              o_start_alu,
  output logic              o_start_mem,
  output logic              o_start_pfcu,
  output logic              o_busy,
  output logic              o_illegal_op,
  output logic [31:0]       o_retired_cnt,
  output logic              o_fault
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ISSUE  = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_RETIRE = 3'd3;
  localparam logic [2:0] S_FLUSH  = 3'd4;

  localparam logic [2:0] C_ALU  = 3'b100;
  localparam logic [2:0] C_MEM  = 3'b010;
  localparam logic [2:0] C_PFCU = 3'b110;
  localparam logic [2:0] C_NOP  = 3'b000;

  localparam int             FC_W          = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FC_W-1:0] C_FLUSH_LAST = FC_W'(FLUSH_CYCLES - 1);

  logic [2:0]      r_state;
  logic [2:0]      w_next;
  logic [2:0]      r_class;
  logic            r_flush_pend;
  logic [FC_W-1:0] r_flush_cnt;
  logic [31:0]     r_retired_cnt;
  logic            r_rq, r_start_alu, r_start_mem, r_start_pfcu, r_busy, r_illegal;

  logic [2:0] w_cls;
  logic       w_unit_op;
  logic       w_issue;
  logic       w_done;
  logic       w_flush;
  logic       w_wd_hit;
  logic       w_rq, w_start_alu, w_start_mem, w_start_pfcu, w_busy, w_illegal;
  logic       w_unused_inst;

  assign w_cls         = i_curr_inst[2:0];
  assign w_unused_inst = ^i_curr_inst[INST_W-1:3];

  always_comb begin
    w_unit_op = (w_cls == C_ALU) || (w_cls == C_MEM) || (w_cls == C_PFCU);
    w_issue   = (r_state == S_IDLE) && i_inst_pres;
    // Only the unit that was started may end the WAIT.
    case (r_class)
      C_ALU:   w_done = i_alu_done;
      C_MEM:   w_done = i_mem_done;
      C_PFCU:  w_done = i_pfcu_done;
      default: w_done = 1'b0;
    endcase
    w_flush = r_flush_pend | i_mdfy_pc;
  end

`ifdef DISPATCH_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] r_wd_cnt;
  logic            r_fault;

  assign w_wd_hit = (r_state == S_WAIT) && !w_done &&
                    (r_wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
  assign o_fault  = r_fault;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wd_cnt <= '0;
      r_fault  <= 1'b0;
    end else begin
      if (r_state == S_WAIT) r_wd_cnt <= r_wd_cnt + WD_W'(1);
      else                   r_wd_cnt <= '0;
      if (w_wd_hit) r_fault <= 1'b1;
    end
  end
`else
  logic [31:0] w_unused_cfg;
  assign w_unused_cfg = TIMEOUT_CYCLES;
  assign w_wd_hit     = 1'b0;
  assign o_fault      = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (i_inst_pres) w_next = w_unit_op ? S_ISSUE : S_RETIRE;
      S_ISSUE:  w_next = S_WAIT;
      S_WAIT:   if (w_done || w_wd_hit) w_next = S_RETIRE;
      S_RETIRE: w_next = w_flush ? S_FLUSH : S_IDLE;
      S_FLUSH:  if (r_flush_cnt == '0) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Outputs are decoded from the state being entered, then registered.
  always_comb begin
    w_busy       = (w_next != S_IDLE);
    w_rq         = (w_next == S_RETIRE);
    w_start_alu  = w_issue && (w_cls == C_ALU);
    w_start_mem  = w_issue && (w_cls == C_MEM);
    w_start_pfcu = w_issue && (w_cls == C_PFCU);
    w_illegal    = w_issue && !w_unit_op && (w_cls != C_NOP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_class       <= C_NOP;
      r_flush_pend  <= 1'b0;
      r_flush_cnt   <= '0;
      r_retired_cnt <= '0;
      r_rq          <= 1'b0;
      r_start_alu   <= 1'b0;
      r_start_mem   <= 1'b0;
      r_start_pfcu  <= 1'b0;
      r_busy        <= 1'b0;
      r_illegal     <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_issue) r_class <= w_cls;
      if (w_next == S_FLUSH)
        r_flush_pend <= 1'b0;
      else if (i_mdfy_pc && ((r_state == S_ISSUE) || (r_state == S_WAIT) || (r_state == S_RETIRE)))
        r_flush_pend <= 1'b1;
      if ((w_next == S_FLUSH) && (r_state != S_FLUSH))
        r_flush_cnt <= C_FLUSH_LAST;
      else if (r_state == S_FLUSH)
        r_flush_cnt <= r_flush_cnt - FC_W'(1);
      if (w_rq) r_retired_cnt <= r_retired_cnt + 32'd1;
      r_rq         <= w_rq;
      r_start_alu  <= w_start_alu;
      r_start_mem  <= w_start_mem;
      r_start_pfcu <= w_start_pfcu;
      r_busy       <= w_busy;
      r_illegal    <= w_illegal;
    end
  end

  assign o_rq_nxt_inst = r_rq;
  assign o_start_alu   = r_start_alu;
  assign o_start_mem   = r_start_mem;
  assign o_start_pfcu  = r_start_pfcu;
  assign o_busy        = r_busy;
  assign o_illegal_op  = r_illegal;
  assign o_retired_cnt = r_retired_cnt;

endmodule

`default_nettype wire
